// File: rtl/karnix_board_io.sv
// karnix_board_io: debounced keys with press/release pulses and PWM LED drive; blink gating when BOARD_IO_BLINK_EN is defined
module karnix_board_io #(
  parameter int KEYS = 4,
  parameter int LEDS = 4,
  parameter int DEBOUNCE_CYCLES = 750000,
  parameter int CNT_W = 20,
  parameter int PWM_W = 8,
  parameter logic [KEYS-1:0] KEY_IDLE = '0,
  parameter int BLINK_CYCLES = 37500000
) (
  input  logic                  io_mainClk,
  input  logic                  io_reset,
  input  logic [KEYS-1:0]       io_key,
  output logic [KEYS-1:0]       io_keyLevel,
  output logic [KEYS-1:0]       io_keyPress,
  output logic [KEYS-1:0]       io_keyRelease,
  input  logic [LEDS-1:0]       io_ledOn,
  input  logic [LEDS*PWM_W-1:0] io_ledDuty,
  input  logic [LEDS-1:0]       io_ledBlink,
  output logic [LEDS-1:0]       io_led
);
  logic [KEYS-1:0] sync1_q, sync2_q, level_q, level_d, press_q, press_d, release_q, release_d;
  logic [KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LEDS-1:0][PWM_W-1:0] shadow_q, shadow_d;
  logic [LEDS-1:0] led_q, led_d, blink_gate;
  always_comb begin
    level_d = level_q;
    press_d = '0;
    release_d = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < KEYS; i++) begin
      if (sync2_q[i] == level_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_d[i] = '0;
        level_d[i] = sync2_q[i];
        press_d[i] = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end
  // shadows reload only on the last count so a period is never cut short
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    shadow_d = &pwm_cnt_q ? io_ledDuty : shadow_q;
    for (int i = 0; i < LEDS; i++)
      led_d[i] = io_ledOn[i] & (pwm_cnt_q < shadow_q[i]) & blink_gate[i];
  end
  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      sync1_q <= KEY_IDLE;
      sync2_q <= KEY_IDLE;
      level_q <= KEY_IDLE;
      press_q <= '0;
      release_q <= '0;
      cnt_q <= '0;
      pwm_cnt_q <= '0;
      shadow_q <= '0;
      led_q <= '0;
    end else begin
      sync1_q <= io_key;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
      cnt_q <= cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      shadow_q <= shadow_d;
      led_q <= led_d;
    end
  end
`ifdef BOARD_IO_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic phase_q, phase_d, wrap;
  always_comb begin
    wrap = blink_cnt_q == BW'(BLINK_CYCLES - 1);
    blink_cnt_d = wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d = phase_q ^ wrap;
  end
  always_ff @(posedge io_mainClk) begin
    if (io_reset) begin
      blink_cnt_q <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q <= phase_d;
    end
  end
  assign blink_gate = ~io_ledBlink | {LEDS{phase_q}};
`else
  logic unused_blink;
  assign unused_blink = ^{io_ledBlink, BLINK_CYCLES[0]};
  assign blink_gate = '1;
`endif
  assign io_keyLevel = level_q;
  assign io_keyPress = press_q;
  assign io_keyRelease = release_q;
  assign io_led = led_q;
endmodule
